// File: rtl/shift_reg_par_in_serial_out_pkg.sv
// Shared helpers for the parallel-in / serial-out shift register.
package shift_reg_par_in_serial_out_pkg;

  // Bits needed to count from 0 up to and including m.
  function automatic int count_width(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/shift_reg_par_in_serial_out.sv
// Parallel-in / serial-out shift register: load M bits, emit one per shift strobe.
// Latency: first bit on bit_out one cycle after set; each shift advances one bit per edge.
// Backpressure: none; caller paces with shift, set always wins and discards remaining bits.
module shift_reg_par_in_serial_out
  import shift_reg_par_in_serial_out_pkg::*;
#(
  parameter int   M         = 8,
  parameter bit   LSB_FIRST = 1'b1,
  parameter logic FILL      = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [M-1:0]              bus_in,
  input  logic                      set,
  input  logic                      shift,
  output logic                      bit_out,
  output logic [count_width(M)-1:0] bits_left,
  output logic                      empty
);

  localparam int CW = count_width(M);

  logic [M-1:0]  data;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      data  <= {M{FILL}};
      count <= '0;
    end else if (set) begin
      data  <= bus_in;
      count <= CW'(M);
    end else if (shift) begin
      if (LSB_FIRST) begin
        data <= {FILL, data[M-1:1]};
      end else begin
        data <= {data[M-2:0], FILL};
      end
      // Idle shifts keep clocking FILL through with the counter parked at 0.
      if (count != '0) begin
        count <= count - 1'b1;
      end
    end
  end

  assign bit_out   = LSB_FIRST ? data[0] : data[M-1];
  assign bits_left = count;
  assign empty     = (count == '0);

endmodule

// File: tb/tb_shift_reg_par_in_serial_out.sv
// Directed bench: LSB-first and MSB-first instances driven in lockstep from one vector table.
module tb_shift_reg_par_in_serial_out;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bus_in;
  logic       set;
  logic       shift;
  logic       bit_l, bit_m;
  logic [3:0] left_l, left_m;
  logic       empty_l, empty_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_reg_par_in_serial_out #(.M(8), .LSB_FIRST(1'b1), .FILL(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .bus_in(bus_in), .set(set), .shift(shift),
    .bit_out(bit_l), .bits_left(left_l), .empty(empty_l)
  );

  shift_reg_par_in_serial_out #(.M(8), .LSB_FIRST(1'b0), .FILL(1'b1)) u_msb (
    .clk(clk), .reset(reset), .bus_in(bus_in), .set(set), .shift(shift),
    .bit_out(bit_m), .bits_left(left_m), .empty(empty_m)
  );

  typedef struct {
    logic       set;
    logic       shift;
    logic [7:0] bus;
    logic       exp_bit_l;
    logic       exp_bit_m;
    logic [3:0] exp_left;
    logic       exp_empty;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic sh, input logic [7:0] b);
    @(negedge clk);
    reset  = r;
    set    = s;
    shift  = sh;
    bus_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic el, input logic em,
                         input logic [3:0] lft, input logic emp);
    chk({name, ".bit_lsb"},   32'(bit_l),   32'(el));
    chk({name, ".bit_msb"},   32'(bit_m),   32'(em));
    chk({name, ".left_lsb"},  32'(left_l),  32'(lft));
    chk({name, ".left_msb"},  32'(left_m),  32'(lft));
    chk({name, ".empty_lsb"}, 32'(empty_l), 32'(emp));
    chk({name, ".empty_msb"}, 32'(empty_m), 32'(emp));
  endtask

  initial begin
    logic [7:0] pat;

    // {set, shift, bus, bit lsb-first, bit msb-first, bits_left, empty}
    tbl[0]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 4'd8, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd7, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 4'd6, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd5, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd4, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 4'd3, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd2, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 4'd1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 4'd0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 4'd0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 4'd0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 4'd8, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd7, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 4'd6, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd5, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 4'd8, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 4'd8, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd7, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 4'd6, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd8, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd7, 1'b0};

    reset  = 1'b1;
    set    = 1'b0;
    shift  = 1'b0;
    bus_in = 8'h00;

    // Reset, then idle: line must sit high with nothing queued.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk_all($sformatf("idle%0d", i), 1'b1, 1'b1, 4'd0, 1'b1);
    end

    for (int i = 0; i < 22; i++) begin
      step(1'b0, tbl[i].set, tbl[i].shift, tbl[i].bus);
      chk_all($sformatf("vec%0d", i), tbl[i].exp_bit_l, tbl[i].exp_bit_m,
              tbl[i].exp_left, tbl[i].exp_empty);
    end

    // Reset mid-transfer of 0x00 after 3 shifts, with shift still asserted.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk_all($sformatf("zero_sh%0d", i), 1'b0, 1'b0, 4'(7 - i), 1'b0);
    end
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk_all("rst_mid", 1'b1, 1'b1, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk_all($sformatf("post_rst%0d", i), 1'b1, 1'b1, 4'd0, 1'b1);
    end

    // Reset must override a simultaneous load.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    chk_all("rst_over_set", 1'b1, 1'b1, 4'd0, 1'b1);

    // UART-style stride: one shift every 4th cycle, each bit held 4 cycles.
    pat = 8'h55;
    step(1'b0, 1'b1, 1'b0, 8'h55);
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("stride_b%0d_c%0d.bit_lsb", b, c), 32'(bit_l), 32'(pat[b]));
        chk($sformatf("stride_b%0d_c%0d.bit_msb", b, c), 32'(bit_m), 32'(pat[7-b]));
        chk($sformatf("stride_b%0d_c%0d.left", b, c), 32'(left_l), 32'(8 - b));
        step(1'b0, 1'b0, (c == 3), 8'h00);
      end
    end
    chk_all("stride_done", 1'b1, 1'b1, 4'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
